alu64_reg: RTL and testbench
============================

Name: alu64_reg

Overview:
- 64-bit integer ALU for the single-cycle/pipelined ARM datapath execute stage.
- Performs pass-B, add, subtract, AND, OR and XOR on two 64-bit operands.
- Produces the result plus negative/zero/overflow/carry_out flags.
- Result and flags are captured in an output register, giving one cycle of latency.

Parameters:
- WIDTH, 64, operand/result width; flag rules reference bit WIDTH-1 (spec values assume 64).

Ports:
- clk        input   1      rising-edge clock
- reset_n    input   1      asynchronous active-low reset
- A          input   64     operand A
- B          input   64     operand B
- cntrl      input   3      operation select
- result     output  64     registered operation result
- negative   output  1      registered result[63]
- zero       output  1      registered (result == 0)
- overflow   output  1      registered signed overflow (add/sub only)
- carry_out  output  1      registered carry out of bit 63 (add/sub only)

Behaviour:
- Reset:
  - Asserting reset_n low immediately forces result=0, negative=0, zero=1, overflow=0, carry_out=0, independent of clk.
  - The first capture occurs on the first rising clk after reset_n returns high.
- Latency and timing:
  - Combinational core computes from A, B and cntrl.
  - All five outputs update together on each rising clk edge: 1-cycle latency, no handshake, a new operation may be issued every cycle.
  - Changes to A/B/cntrl between edges do not affect the outputs until the next edge.
- Operation decode (cntrl):
  - 000: B
  - 010: A+B
  - 011: A-B
  - 100: A&B
  - 101: A|B
  - 110: A^B
  - 001 and 111 are reserved: result=0, overflow=0, carry_out=0.
- Arithmetic:
  - Ripple structure of 64 one-bit slices.
  - Subtract is A + ~B + 1: B inverted per slice, carry-in to bit 0 = cntrl[0].
  - Add uses carry-in 0.
  - All sums are modulo 2^64 (wrap-around, no saturation).
- Flags:
  - negative = result[63] for every opcode.
  - zero = 1 iff all 64 result bits are 0, for every opcode.
  - For add/sub: carry_out = carry out of bit 63; overflow = carry_into_bit63 XOR carry_out_of_bit63.
  - For pass-B, logical and reserved ops: overflow=0, carry_out=0.
  - For subtract, carry_out=1 means no borrow (A >= B unsigned).
- Boundary cases:
  - 0-0 gives result 0, zero=1, carry_out=1, overflow=0.
  - Max positive + 1 gives signed overflow.
  - All-ones + 1 wraps to 0 with carry_out=1 and overflow=0.
  - Reset asserted mid-stream discards the in-flight result; outputs hold reset values while reset_n is low.

Test Plan:
- Reset: hold reset_n=0 with any inputs -> result=0, zero=1, negative=overflow=carry_out=0; release and apply cntrl=000, B=5 -> after one edge result=5, zero=0.
- Pass-B/logical: A=0xF0F0_0000_0000_00FF, B=0x8000_0000_0000_0F0F:
  - cntrl 000 -> result=B, negative=1
  - cntrl 100 -> 0x8000_0000_0000_000F
  - cntrl 101 -> 0xF0F0_0000_0000_0FFF
  - cntrl 110 -> 0x70F0_0000_0000_0FF0
  - overflow=carry_out=0 for all four.
- Add overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, cntrl=010 -> result=0x8000_0000_0000_0000, overflow=1, negative=1, carry_out=0, zero=0.
- Add wrap: A=0xFFFF_FFFF_FFFF_FFFF, B=1, cntrl=010 -> result=0, zero=1, carry_out=1, overflow=0.
- Subtract: A=5, B=5, cntrl=011 -> result=0, zero=1, carry_out=1. A=3, B=5 -> result=0xFFFF_FFFF_FFFF_FFFE, negative=1, carry_out=0, overflow=0. A=0x8000_0000_0000_0000, B=1 -> overflow=1.
- Random regression: 100 random A/B per opcode; each output one edge later must equal the golden model (result, negative=result[63], zero=(result==0)); reserved cntrl=111 -> result=0, zero=1.

Source files
------------

// File: rtl/alu64_reg.sv
// 64-bit execute-stage ALU with a ripple-carry adder/subtractor.
// Result and NZVC flags are registered, giving one cycle of latency.
module alu64_reg #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    localparam logic [2:0] OP_PASS_B = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b010;
    localparam logic [2:0] OP_SUB    = 3'b011;
    localparam logic [2:0] OP_AND    = 3'b100;
    localparam logic [2:0] OP_OR     = 3'b101;
    localparam logic [2:0] OP_XOR    = 3'b110;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   carry;

    logic [WIDTH-1:0] result_d, result_q;
    logic             negative_d, negative_q;
    logic             zero_d, zero_q;
    logic             overflow_d, overflow_q;
    logic             carry_out_d, carry_out_q;

    // Ripple chain of one-bit full adders; cntrl[0] both inverts B and injects the +1 for subtract.
    always_comb begin
        b_eff    = cntrl[0] ? ~B : B;
        carry    = '0;
        sum      = '0;
        carry[0] = cntrl[0];
        for (int i = 0; i < int'(WIDTH); i++) begin
            sum[i]     = A[i] ^ b_eff[i] ^ carry[i];
            carry[i+1] = (A[i] & b_eff[i]) | (carry[i] & (A[i] ^ b_eff[i]));
        end
    end

    // Operation select and flag generation.
    always_comb begin
        result_d    = '0;
        overflow_d  = 1'b0;
        carry_out_d = 1'b0;
        case (cntrl)
            OP_PASS_B: result_d = B;
            OP_ADD, OP_SUB: begin
                result_d    = sum;
                carry_out_d = carry[WIDTH];
                overflow_d  = carry[WIDTH] ^ carry[WIDTH-1];
            end
            OP_AND:    result_d = A & B;
            OP_OR:     result_d = A | B;
            OP_XOR:    result_d = A ^ B;
            default:   result_d = '0;
        endcase
        negative_d = result_d[WIDTH-1];
        zero_d     = (result_d == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q    <= '0;
            negative_q  <= 1'b0;
            zero_q      <= 1'b1;
            overflow_q  <= 1'b0;
            carry_out_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            negative_q  <= negative_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            carry_out_q <= carry_out_d;
        end
    end

    assign result    = result_q;
    assign negative  = negative_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign carry_out = carry_out_q;

endmodule

// File: tb/tb_alu64_reg.sv
// Directed bench for alu64_reg: reset behaviour, logical ops, add/sub boundaries
// and a short randomised sweep against an arithmetic golden model.
module tb_alu64_reg;

    logic        clk;
    logic        reset_n;
    logic [63:0] A;
    logic [63:0] B;
    logic [2:0]  cntrl;
    logic [63:0] result;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry_out;

    int checks = 0;
    int errors = 0;

    alu64_reg #(.WIDTH(64)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .A         (A),
        .B         (B),
        .cntrl     (cntrl),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every output against an expected result and V/C, with N/Z derived from the result.
    task automatic check_all(input string tag, input logic [63:0] er, input logic ev, input logic ec);
        check({tag, ".result"},    result,          er);
        check({tag, ".negative"},  64'(negative),   64'(er[63]));
        check({tag, ".zero"},      64'(zero),       64'(er == 64'd0));
        check({tag, ".overflow"},  64'(overflow),   64'(ev));
        check({tag, ".carry_out"}, 64'(carry_out),  64'(ec));
    endtask

    // Drive one operation, let one rising edge capture it, sample 1 time unit later.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [2:0] c);
        A     = a;
        B     = b;
        cntrl = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] ra, rb, bb, er;
        logic [64:0] wide;
        logic        ev, ec;
        logic [2:0]  ops [6];

        ops[0] = 3'b000; ops[1] = 3'b010; ops[2] = 3'b011;
        ops[3] = 3'b100; ops[4] = 3'b101; ops[5] = 3'b110;

        // Reset held low with an active add on the inputs must keep reset values.
        reset_n = 1'b0;
        A       = 64'd1;
        B       = 64'd1;
        cntrl   = 3'b010;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset_hold", 64'd0, 1'b0, 1'b0);

        @(negedge clk);
        reset_n = 1'b1;
        issue(64'd0, 64'd5, 3'b000);
        check_all("first_pass_b", 64'd5, 1'b0, 1'b0);

        issue(64'hF0F0_0000_0000_00FF, 64'h8000_0000_0000_0F0F, 3'b000);
        check_all("pass_b", 64'h8000_0000_0000_0F0F, 1'b0, 1'b0);
        issue(64'hF0F0_0000_0000_00FF, 64'h8000_0000_0000_0F0F, 3'b100);
        check_all("and", 64'h8000_0000_0000_000F, 1'b0, 1'b0);
        issue(64'hF0F0_0000_0000_00FF, 64'h8000_0000_0000_0F0F, 3'b101);
        check_all("or", 64'hF0F0_0000_0000_0FFF, 1'b0, 1'b0);
        issue(64'hF0F0_0000_0000_00FF, 64'h8000_0000_0000_0F0F, 3'b110);
        check_all("xor", 64'h70F0_0000_0000_0FF0, 1'b0, 1'b0);

        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
        check_all("add_ovf", 64'h8000_0000_0000_0000, 1'b1, 1'b0);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
        check_all("add_wrap", 64'd0, 1'b0, 1'b1);
        issue(64'd0, 64'd0, 3'b010);
        check_all("add_zero", 64'd0, 1'b0, 1'b0);

        issue(64'd5, 64'd5, 3'b011);
        check_all("sub_eq", 64'd0, 1'b0, 1'b1);
        issue(64'd0, 64'd0, 3'b011);
        check_all("sub_zero", 64'd0, 1'b0, 1'b1);
        issue(64'd3, 64'd5, 3'b011);
        check_all("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        issue(64'h8000_0000_0000_0000, 64'd1, 3'b011);
        check_all("sub_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);

        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b111);
        check_all("rsvd_111", 64'd0, 1'b0, 1'b0);
        issue(64'h1234, 64'h5678, 3'b001);
        check_all("rsvd_001", 64'd0, 1'b0, 1'b0);

        // Input changes between edges must not reach the outputs.
        issue(64'd10, 64'd20, 3'b010);
        A = 64'd99;
        B = 64'd1;
        cntrl = 3'b011;
        #3;
        check_all("hold_between_edges", 64'd30, 1'b0, 1'b0);

        // Asynchronous reset mid-stream discards the captured result without a clock edge.
        @(negedge clk);
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
        #1;
        reset_n = 1'b0;
        #1;
        check_all("async_reset", 64'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_all("reset_low_edge", 64'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // Randomised sweep: golden model uses a 65-bit wide add and sign comparison.
        for (int k = 0; k < 6; k++) begin
            for (int n = 0; n < 100; n++) begin
                ra = {$urandom, $urandom};
                rb = {$urandom, $urandom};
                if (n == 0) rb = ra;
                ev = 1'b0;
                ec = 1'b0;
                case (ops[k])
                    3'b000: er = rb;
                    3'b100: er = ra & rb;
                    3'b101: er = ra | rb;
                    3'b110: er = ra ^ rb;
                    default: begin
                        bb   = (ops[k] == 3'b011) ? ~rb : rb;
                        wide = {1'b0, ra} + {1'b0, bb} + 65'(ops[k] == 3'b011);
                        er   = wide[63:0];
                        ec   = wide[64];
                        ev   = (ra[63] == bb[63]) && (er[63] != ra[63]);
                    end
                endcase
                issue(ra, rb, ops[k]);
                check_all($sformatf("rand_op%0d_%0d", k, n), er, ev, ec);
            end
        end

        issue({$urandom, $urandom}, {$urandom, $urandom}, 3'b111);
        check_all("rand_rsvd", 64'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
